// File: rtl/zone_pkg.sv
// Shared constants and FSM encoding for the zone-gray LED transmitter.
// Zone geometry is 15 rows x 24 columns, one 16-bit gray value per zone.
package zone_pkg;

  localparam int ZONES      = 360;
  localparam int GRAY_W     = 16;
  localparam int ZONE_COLS  = 24;
  localparam int ZONE_IDX_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_LATCH
  } state_t;

endpackage

// File: rtl/zone_ram.sv
// Ping-pong zone buffer: simple dual-port RAM, one write port and one
// registered read port (1-cycle latency). Contents are not reset.
module zone_ram #(
  parameter int DEPTH = 720,
  parameter int W     = 16,
  parameter int AW    = 10
) (
  input  logic          sys_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/zone_tx.sv
// Zone transmitter: captures zone gray values into a ping-pong buffer and
// serialises each completed frame MSB-first over an sclk/sdi/le link.
//   in : sys_clk, sys_rst (async, low), new_frame, update, index, gray
//   out: led_sclk, led_sdi, led_le, busy, overrun
module zone_tx
  import zone_pkg::*;
#(
  parameter int N_ZONES   = ZONES,
  parameter int CLK_DIV   = 4,
  parameter int LE_CYCLES = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  new_frame,
  input  logic                  update,
  input  logic [ZONE_IDX_W-1:0] index,
  input  logic [GRAY_W-1:0]     gray,
  output logic                  led_sclk,
  output logic                  led_sdi,
  output logic                  led_le,
  output logic                  busy,
  output logic                  overrun
);

  localparam int AW = $clog2(2 * N_ZONES);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW = (LE_CYCLES > 1) ? $clog2(LE_CYCLES) : 1;
  localparam int BW = $clog2(GRAY_W);

  localparam logic [AW-1:0] BANK_OFS = AW'(N_ZONES);
  localparam logic [ZONE_IDX_W-1:0] ZLIM = ZONE_IDX_W'(N_ZONES);
  localparam logic [ZONE_IDX_W-1:0] ZLAST = ZONE_IDX_W'(N_ZONES - 1);
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LE_END = LW'(LE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_TOP = BW'(GRAY_W - 1);

  state_t                  state;
  logic                    update_d;
  logic                    wr_bank;
  logic [ZONE_IDX_W-1:0]   zone;
  logic [DW-1:0]           div_cnt;
  logic [LW-1:0]           le_cnt;
  logic [BW-1:0]           bit_cnt;
  // MSB already sits in led_sdi, so only the remaining bits are kept
  logic [GRAY_W-2:0]       shreg;

  logic                    we;
  logic [AW-1:0]           waddr;
  logic [AW-1:0]           raddr;
  logic [GRAY_W-1:0]       rdata;

  assign we    = update & ~update_d & (index < ZLIM);
  assign waddr = AW'(index) + (wr_bank ? BANK_OFS : '0);
  // read bank is always the one not being written
  assign raddr = AW'(zone) + (wr_bank ? '0 : BANK_OFS);

  zone_ram #(
    .DEPTH (2 * N_ZONES),
    .W     (GRAY_W),
    .AW    (AW)
  ) u_ram (
    .sys_clk (sys_clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (gray),
    .raddr   (raddr),
    .rdata   (rdata)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) update_d <= 1'b0;
    else          update_d <= update;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state    <= S_IDLE;
      wr_bank  <= 1'b0;
      zone     <= '0;
      div_cnt  <= '0;
      le_cnt   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      led_sclk <= 1'b0;
      led_sdi  <= 1'b0;
      led_le   <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= new_frame & (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (new_frame) begin
            wr_bank <= ~wr_bank;
            busy    <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          shreg   <= rdata[GRAY_W-2:0];
          led_sdi <= rdata[GRAY_W-1];
          bit_cnt <= BIT_TOP;
          div_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt == DIV_END) begin
            div_cnt <= '0;
            if (!led_sclk) begin
              led_sclk <= 1'b1;
            end else begin
              led_sclk <= 1'b0;
              if (bit_cnt == '0) begin
                led_sdi <= 1'b0;
                if (zone == ZLAST) begin
                  led_le <= 1'b1;
                  le_cnt <= '0;
                  state  <= S_LATCH;
                end else begin
                  zone  <= zone + 1'b1;
                  state <= S_FETCH;
                end
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
                led_sdi <= shreg[GRAY_W-2];
                shreg   <= {shreg[GRAY_W-3:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (le_cnt == LE_END) begin
            led_le <= 1'b0;
            busy   <= 1'b0;
            zone   <= '0;
            state  <= S_IDLE;
          end else begin
            le_cnt <= le_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zone_tx.sv
// Self-checking bench for zone_tx: table-driven zone writes plus
// directed frame, ping-pong, overrun and reset sequences.
module tb_zone_tx;
  import zone_pkg::*;

  localparam int ZN    = 20;
  localparam int DIV   = 4;
  localparam int LEC   = 8;
  localparam int ZT    = 2 + 2 * DIV * GRAY_W;
  localparam int FRAME = ZN * ZT + LEC;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        new_frame = 1'b0;
  logic        update = 1'b0;
  logic [8:0]  index = '0;
  logic [15:0] gray = '0;
  logic        led_sclk, led_sdi, led_le, busy, overrun;

  zone_tx #(
    .N_ZONES   (ZN),
    .CLK_DIV   (DIV),
    .LE_CYCLES (LEC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .new_frame (new_frame),
    .update    (update),
    .index     (index),
    .gray      (gray),
    .led_sclk  (led_sclk),
    .led_sdi   (led_sdi),
    .led_le    (led_le),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          idx;
    logic [15:0] g;
    int          hold;
    int          chk;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [9];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model [2][ZN];
  int          mwb = 0;
  int          eb = 0;
  logic [15:0] rxq [$];
  logic [15:0] rx_sh = '0;
  int          rx_nb = 0;
  int          busy_cnt = 0;
  int          le_cnt = 0;
  int          ov_cnt = 0;
  int          viol = 0;
  logic        prev_sdi = 1'b0;

  // board-side receiver
  always @(posedge led_sclk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_nb = 0;
    end else begin
      rx_sh = {rx_sh[14:0], led_sdi};
      rx_nb++;
      if (rx_nb == 16) begin
        rxq.push_back(rx_sh);
        rx_nb = 0;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (busy) busy_cnt++;
    if (led_le) le_cnt++;
    if (overrun) ov_cnt++;
    if ((led_sdi !== prev_sdi && led_sclk) || (led_le && led_sclk))
      viol++;
    prev_sdi = led_sdi;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic write_zone(input int idx, input logic [15:0] g,
                            input int hold);
    @(negedge sys_clk);
    index  = 9'(idx);
    gray   = g;
    update = 1'b1;
    repeat (hold) @(negedge sys_clk);
    update = 1'b0;
    if (idx < ZN) model[mwb][idx] = g;
  endtask

  task automatic fill(input int mult, input int add);
    for (int i = 0; i < ZN; i++)
      write_zone(i, 16'(i * mult + add), 2);
  endtask

  task automatic pulse_frame(input bit wr, input int idx,
                             input logic [15:0] g);
    @(negedge sys_clk);
    rxq.delete();
    busy_cnt  = 0;
    le_cnt    = 0;
    viol      = 0;
    eb        = mwb;
    new_frame = 1'b1;
    if (wr) begin
      index  = 9'(idx);
      gray   = g;
      update = 1'b1;
      model[mwb][idx] = g;
    end
    mwb = 1 - mwb;
    @(negedge sys_clk);
    new_frame = 1'b0;
    if (wr) begin
      @(negedge sys_clk);
      update = 1'b0;
    end
  endtask

  task automatic wait_frame(input string nm);
    int n;
    logic [31:0] act;
    n = 0;
    check({nm, "_busy_up"}, 32'(busy), 1);
    while (busy && n < FRAME + 50) begin
      @(negedge sys_clk);
      n++;
    end
    check({nm, "_busy_down"}, 32'(busy), 0);
    @(negedge sys_clk);
    check({nm, "_words"}, rxq.size(), ZN);
    for (int i = 0; i < ZN; i++) begin
      act = (i < rxq.size()) ? {16'h0, rxq[i]} : 32'hFFFF_FFFF;
      check($sformatf("%s_zone%0d", nm, i), act, {16'h0, model[eb][i]});
    end
    check({nm, "_busy_cycles"}, busy_cnt, FRAME);
    check({nm, "_le_cycles"}, le_cnt, LEC);
    check({nm, "_link_timing"}, viol, 0);
  endtask

  initial begin
    logic [31:0] act;
    tbl[0] = '{0,   16'hA5C3, 11, 0,  16'hA5C3};
    tbl[1] = '{19,  16'h8001, 3,  19, 16'h8001};
    tbl[2] = '{7,   16'h1234, 1,  7,  16'h5678};
    tbl[3] = '{7,   16'h5678, 2,  7,  16'h5678};
    tbl[4] = '{400, 16'hFFFF, 3,  16, 16'h0000};
    tbl[5] = '{20,  16'hFFFF, 2,  0,  16'hA5C3};
    tbl[6] = '{12,  16'hFFFF, 2,  12, 16'hFFFF};
    tbl[7] = '{3,   16'h8000, 4,  3,  16'h8000};
    tbl[8] = '{4,   16'h0001, 2,  4,  16'h0001};

    repeat (3) @(negedge sys_clk);
    check("reset_outs", {27'h0, led_sclk, led_sdi, led_le, busy, overrun},
          0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("idle_outs", {27'h0, led_sclk, led_sdi, led_le, busy, overrun},
          0);

    // single-write frame driven by the vector table
    fill(0, 0);
    for (int i = 0; i < 9; i++)
      write_zone(tbl[i].idx, tbl[i].g, tbl[i].hold);
    pulse_frame(0, 0, 16'h0);
    wait_frame("table");
    for (int i = 0; i < 9; i++) begin
      act = (tbl[i].chk < rxq.size()) ? {16'h0, rxq[tbl[i].chk]}
                                      : 32'hFFFF_FFFF;
      check($sformatf("tbl%0d", i), act, {16'h0, tbl[i].exp});
    end

    // ordering: gray = index
    fill(1, 0);
    pulse_frame(0, 0, 16'h0);
    wait_frame("order");
    check("order_last", (rxq.size() == ZN) ? {16'h0, rxq[ZN-1]} : 0,
          ZN - 1);

    // ping-pong isolation with an overrun mid-stream
    fill(0, 16'h1111);
    pulse_frame(0, 0, 16'h0);
    ov_cnt = 0;
    fork
      begin
        fill(0, 16'h2222);
        @(negedge sys_clk);
        ov_cnt    = 0;
        new_frame = 1'b1;
        @(negedge sys_clk);
        new_frame = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("overrun_pulse", ov_cnt, 1);
      end
      wait_frame("pp_a");
    join
    check("overrun_once", ov_cnt, 1);
    check("pp_a_val", (rxq.size() > 5) ? {16'h0, rxq[5]} : 0, 16'h1111);

    // frame B, with an update edge in the same cycle as new_frame
    ov_cnt = 0;
    pulse_frame(1, 2, 16'h3333);
    wait_frame("pp_b");
    check("pp_b_val", (rxq.size() > 5) ? {16'h0, rxq[5]} : 0, 16'h2222);
    check("pp_b_same_cyc", (rxq.size() > 2) ? {16'h0, rxq[2]} : 0,
          16'h3333);
    check("no_overrun_idle", ov_cnt, 0);

    // reset during zone 10
    fill(3, 7);
    pulse_frame(0, 0, 16'h0);
    repeat (10 * ZT + 40) @(negedge sys_clk);
    check("rst_pre_busy", 32'(busy), 1);
    check("rst_pre_sclk", 32'(led_sclk), 1);
    check("rst_pre_words", rxq.size(), 10);
    sys_rst = 1'b0;
    #1;
    check("rst_outs", {27'h0, led_sclk, led_sdi, led_le, busy, overrun},
          0);
    repeat (3) @(negedge sys_clk);
    check("rst_hold_le", 32'(led_le), 0);
    sys_rst = 1'b1;
    mwb = 0;
    fill(5, 1);
    pulse_frame(0, 0, 16'h0);
    wait_frame("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
